// File: rtl/divu_seq_pkg.sv
// Shared CPU constants for the multiply/divide unit: datapath width, the
// sequential divider state encoding and the divide-by-zero quotient constant.
package divu_seq_pkg;

    localparam int XLEN = 32;

    // Multiply/divide unit latencies, in cycles after the accepting edge.
    localparam int MDU_MUL_CYCLES = 1;
    localparam int MDU_DIV_CYCLES = XLEN;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } divu_state_e;

    // Every quotient bit of a divide by zero is this value (MIPS-style all ones).
    localparam logic DIV0_QBIT = 1'b1;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle MSB first.
// Produces MIPS HI (remainder) / LO (quotient) after WIDTH busy cycles.
module divu_seq
    import divu_seq_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] high,
    output logic [WIDTH-1:0] low
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    divu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, div_q;
    logic             accept, finish;

    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_next, quo_next;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);

    // Shift the next dividend bit into the partial remainder and try the subtract.
    assign trial    = {rem_q, quo_q[WIDTH-1]};
    assign ge       = (trial >= {1'b0, div_q});
    assign rem_next = ge ? WIDTH'(trial - {1'b0, div_q}) : trial[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], ge};

    // The working registers need no reset: they are reloaded on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q <= '0;
            quo_q <= a;
            div_q <= b;
        end else if (busy) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            done  <= 1'b0;
            high  <= '0;
            low   <= '0;
        end else begin
            done <= finish;
            if (accept || finish) begin
                cnt_q <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (finish) begin
                high <= rem_next;
                low  <= (div_q == '0) ? {WIDTH{DIV0_QBIT}} : quo_next;
            end
        end
    end

endmodule

// File: tb/tb_divu_seq.sv
// Self-checking bench for divu_seq: directed corner cases plus random
// operands, compared against plain-arithmetic quotient/remainder.
module tb_divu_seq;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] high, low;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    divu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .high  (high),
        .low   (low)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] x, input logic [W-1:0] y);
        return (y == 0) ? {W{1'b1}} : x / y;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] x, input logic [W-1:0] y);
        return (y == 0) ? x : x % y;
    endfunction

    // Request on the next edge; returns at the negedge of busy cycle 1 with
    // the operand buses scrambled to prove they were latched.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb);
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Counts the remaining busy cycles, then checks the done-cycle outputs.
    task automatic finish_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                             input int already);
        int n;
        n = already;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, W'(n), W'(32));
        check({tag, " done"}, W'(done), W'(1));
        check({tag, " low"}, low, ref_q(ta, tb));
        check({tag, " high"}, high, ref_r(ta, tb));
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb);
        start_op(ta, tb);
        finish_op(tag, ta, tb, 0);
        @(negedge clk);
        check({tag, " done_drop"}, W'(done), W'(0));
        check({tag, " low_hold"}, low, ref_q(ta, tb));
    endtask

    initial begin
        int d0;
        logic [W-1:0] ra, rb;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("rst busy", W'(busy), W'(0));
        check("rst done", W'(done), W'(0));
        check("rst high", high, W'(0));
        check("rst low",  low,  W'(0));
        start = 1'b0;
        reset = 1'b0;

        full_op("100/7", 32'd100, 32'd7);
        full_op("max/1", 32'hFFFF_FFFF, 32'd1);
        full_op("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        full_op("5/0", 32'd5, 32'd0);

        // A second start while busy must be ignored.
        d0 = done_cnt;
        start_op(32'd20, 32'd3);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        finish_op("20/3 ignore", 32'd20, 32'd3, 5);
        @(negedge clk);
        check("20/3 one_done", W'(done_cnt - d0), W'(1));

        // Reset mid-divide aborts without a done pulse.
        d0 = done_cnt;
        start_op(32'd1000, 32'd10);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", W'(busy), W'(0));
        check("abort high", high, W'(0));
        check("abort low",  low,  W'(0));
        repeat (40) @(negedge clk);
        check("abort no_done", W'(done_cnt - d0), W'(0));
        full_op("9/4", 32'd9, 32'd4);

        // Back-to-back: new request accepted in the done cycle.
        start_op(32'd7, 32'd2);
        finish_op("7/2", 32'd7, 32'd2, 0);
        start = 1'b1;
        a     = 32'd50;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check("b2b done_drop", W'(done), W'(0));
        check("b2b busy", W'(busy), W'(1));
        check("b2b low_hold", low, 32'd3);
        finish_op("50/5", 32'd50, 32'd5, 0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 255);
                2: rb = ra >> $urandom_range(0, 31);
                default: rb = (i == 7) ? 32'd0 : 32'($urandom_range(0, 3));
            endcase
            full_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divu_seq.md
DIVU_SEQ -- requirements
Module: divu_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request to begin a divide; sampled only while busy=0.
REQ-005 SHALL provide port a  input  WIDTH  unsigned dividend; sampled on the accepting edge.
REQ-006 SHALL provide port b  input  WIDTH  unsigned divisor; sampled on the accepting edge.
REQ-007 SHALL provide port busy  output  1  divide in progress; pipeline stall request.
REQ-008 SHALL provide port done  output  1  one-cycle pulse; high/low were updated on this cycle's starting edge.
REQ-009 SHALL provide port high  output  WIDTH  remainder (MIPS HI).
REQ-010 SHALL provide port low  output  WIDTH  quotient (MIPS LO).

Function
REQ-011 SHALL accept a request on any edge where start=1 and busy=0 (the accept edge); operands are latched internally, so a/b may change afterwards.
REQ-012 SHALL keep busy=1 for exactly WIDTH cycles after the accept edge and drop busy on the completion edge, i.e. the WIDTH-th edge after the accept edge.
REQ-013 SHALL use restoring radix-2 division: one quotient bit per cycle, MSB first, (WIDTH+1)-bit partial-remainder compare/subtract.
REQ-014 SHALL use a 0..WIDTH-1 iteration counter; completion occurs on the edge where the counter equals WIDTH-1.
REQ-015 SHALL, on the completion edge, load low=floor(a/b) and high=a mod b, and assert done for exactly the following cycle.
REQ-016 SHALL, for b=0, use the same latency and produce low={WIDTH{1'b1}} and high=a.
REQ-017 SHALL ignore start while busy=1; the operation in flight is unaffected.
REQ-018 SHALL accept start in the cycle in which done=1, because busy=0 in that cycle; done then deasserts and busy reasserts on that edge.
REQ-019 SHALL hold high/low stable between completion edges; an accept edge does not disturb them.
REQ-020 SHALL implement a state machine with states IDLE (busy=0) and RUN (busy=1): IDLE->RUN on accept; RUN->IDLE on completion; any state->IDLE on reset.
REQ-021 SHALL keep done combinationally independent of start, a and b (registered output).

Reset
REQ-022 SHALL, on any edge with reset=1, set state=IDLE, busy=0, done=0, high=0, low=0 and counter=0, with priority over start.
REQ-023 SHALL, if reset is asserted mid-divide, abort the divide with no done pulse and no result update; the first accept edge after reset starts a fresh divide.

Structure
REQ-024 SHALL take WIDTH, the state encoding (IDLE, RUN) and the divide-by-zero quotient constant from the shared CPU package, alongside the multiply/divide unit constants.
REQ-025 SHALL be a single flat module with no sub-module; the counter, subtractor and state register are all local.

Verification
REQ-026 a=100, b=7, start pulse -> busy high 32 cycles, then done=1 with low=14 and high=2.
REQ-027 a=0xFFFFFFFF, b=1 -> low=0xFFFFFFFF, high=0; then a=0xFFFFFFFF, b=0xFFFFFFFF -> low=1, high=0.
REQ-028 a=5, b=0 -> after 32 cycles low=0xFFFFFFFF, high=5, done pulse.
REQ-029 Start 20/3; at busy cycle 5 drive start=1 with a=9, b=9 -> result still low=6, high=2, exactly one done pulse.
REQ-030 Start 1000/10; assert reset at busy cycle 10 -> busy=0, high=0, low=0 and no done pulse; then 9/4 -> low=2, high=1 after 32 cycles.
REQ-031 Issue start with 50/5 in the done cycle of 7/2 -> first done gives low=3, high=1; second done, 32 cycles later, gives low=10, high=0.
